stdp_update_scheduler: RTL

- Sequences STDP weight updates for the 5 presynaptic-to-postsynaptic synapses around the LIF neuron array.
- Timestamps pre and post spikes, turns close spike pairs into per-synapse LTP/LTD requests, and round-robin arbitrates them onto one shared weight-update engine.
- Holds the synaptic weight registers that scale presynaptic spikes into the postsynaptic current.

---
 rtl/stdp_pkg.sv | 28 ++
 rtl/stdp_rr_arbiter.sv | 31 +++
 rtl/stdp_update_scheduler.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/stdp_pkg.sv
// Shared types and defaults for the STDP update scheduler.
package stdp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam int unsigned DEF_W_INIT    = 64;
  localparam int unsigned DEF_A_PLUS    = 16;
  localparam int unsigned DEF_A_MINUS   = 8;
  localparam int unsigned DEF_TAU_SHIFT = 2;
  localparam int unsigned DEF_T_WINDOW  = 16;

  // Weight step for a spike pair dt cycles apart: amp >> (dt >> tau_shift),
  // forced to 0 once the shift would empty a w_width-bit value.
  function automatic int unsigned stdp_dw(input int unsigned amp,
                                          input int unsigned dt,
                                          input int unsigned tau_shift,
                                          input int unsigned w_width);
    int unsigned sh;
    sh = dt >> tau_shift;
    if (sh >= w_width) return 0;
    return amp >> sh;
  endfunction

endpackage

// File: rtl/stdp_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping.
module stdp_rr_arbiter #(
  parameter int unsigned N  = 5,
  parameter int unsigned IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  // Scan indices ptr, ptr+1, ... modulo N and take the first one requesting.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'((32'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/stdp_update_scheduler.sv
// STDP update scheduler: spike timers, LTP/LTD request capture, round-robin
// weight-update engine and the synaptic weight registers.
// Optional macro STDP_WEIGHT_LOAD_EN adds a direct weight-write port.
module stdp_update_scheduler import stdp_pkg::*; #(
  parameter int unsigned N_SYN     = 5,
  parameter int unsigned W_WIDTH   = 8,
  parameter int unsigned T_WIDTH   = 8,
  parameter int unsigned T_WINDOW  = DEF_T_WINDOW,
  parameter int unsigned W_INIT    = DEF_W_INIT,
  parameter int unsigned A_PLUS    = DEF_A_PLUS,
  parameter int unsigned A_MINUS   = DEF_A_MINUS,
  parameter int unsigned TAU_SHIFT = DEF_TAU_SHIFT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_SYN-1:0]         pre_spike,
  input  logic                     post_spike,
  input  logic                     learn_en,
`ifdef STDP_WEIGHT_LOAD_EN
  input  logic                     wr_en,
  input  logic [2:0]               wr_idx,
  input  logic [W_WIDTH-1:0]       wr_data,
`endif
  output logic [N_SYN*W_WIDTH-1:0] weights,
  output logic                     busy,
  output logic                     upd_valid,
  output logic [2:0]               upd_idx,
  output logic                     upd_ltp,
  output logic [W_WIDTH-1:0]       upd_weight,
  output logic                     upd_sat
);

  localparam logic [T_WIDTH-1:0] T_WIN = T_WIDTH'(T_WINDOW);

  state_t               state, state_n;
  logic                 grab, do_calc, do_write;

  logic [T_WIDTH-1:0]   pre_timer [N_SYN];
  logic [T_WIDTH-1:0]   post_timer;

  logic [N_SYN-1:0]     pend_ltp, pend_ltd, pend_ltp_n, pend_ltd_n;
  logic [N_SYN-1:0]     set_ltp, set_ltd, clr_ltp, clr_ltd, wr_mask;
  logic [T_WIDTH-1:0]   dt_ltp [N_SYN];
  logic [T_WIDTH-1:0]   dt_ltd [N_SYN];
  logic [T_WIDTH-1:0]   cap_dt_ltp [N_SYN];

  logic [W_WIDTH-1:0]   w [N_SYN];

  logic [2:0]           ptr, sel;
  logic                 kind;
  logic [T_WIDTH-1:0]   dt_sel;

  logic [N_SYN-1:0]     grant;
  logic [2:0]           arb_idx;
  logic                 arb_any;
  logic                 grab_ltp;
  logic [T_WIDTH-1:0]   grab_dt;

  logic [W_WIDTH-1:0]   dw, w_cur, w_new;
  logic [W_WIDTH:0]     w_sum, w_diff;
  logic                 w_sat;

  stdp_rr_arbiter #(.N(N_SYN), .IW(3)) u_arb (
    .req   (pend_ltp | pend_ltd),
    .ptr   (ptr),
    .grant (grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign grab_ltp = |(pend_ltp & grant);
  assign grab_dt  = grab_ltp ? dt_ltp[arb_idx] : dt_ltd[arb_idx];
  assign busy     = (state != IDLE) || (|(pend_ltp | pend_ltd));
  assign w_cur    = w[sel];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // FSM next state and per-state strobes.
  always_comb begin
    state_n  = state;
    grab     = 1'b0;
    do_calc  = 1'b0;
    do_write = 1'b0;
    unique case (state)
      IDLE: begin
        if (arb_any) begin
          grab    = 1'b1;
          state_n = CALC;
        end
      end
      CALC: begin
        do_calc = 1'b1;
        state_n = WRITE;
      end
      WRITE: begin
        do_write = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Spike timers: load 1 on a spike, otherwise count up and saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_SYN; i++) pre_timer[i] <= '1;
      post_timer <= '1;
    end else begin
      for (int unsigned i = 0; i < N_SYN; i++) begin
        if (pre_spike[i])            pre_timer[i] <= T_WIDTH'(1);
        else if (pre_timer[i] != '1) pre_timer[i] <= pre_timer[i] + T_WIDTH'(1);
      end
      if (post_spike)            post_timer <= T_WIDTH'(1);
      else if (post_timer != '1) post_timer <= post_timer + T_WIDTH'(1);
    end
  end

  // Request capture from pre-load timer values; a coincident pre/post pair is
  // pure LTP at dt=0. Sets beat the engine's clear, a config write beats both.
  always_comb begin
    set_ltp = '0;
    set_ltd = '0;
    clr_ltp = '0;
    clr_ltd = '0;
    wr_mask = '0;
    for (int unsigned i = 0; i < N_SYN; i++) begin
      cap_dt_ltp[i] = pre_spike[i] ? '0 : pre_timer[i];
      if (learn_en && post_spike && (pre_spike[i] || (pre_timer[i] < T_WIN)))
        set_ltp[i] = 1'b1;
      if (learn_en && pre_spike[i] && !post_spike && (post_timer < T_WIN))
        set_ltd[i] = 1'b1;
    end
    if (grab) begin
      if (grab_ltp) clr_ltp = grant;
      else          clr_ltd = grant;
    end
`ifdef STDP_WEIGHT_LOAD_EN
    if (wr_en && (32'(wr_idx) < N_SYN)) wr_mask[wr_idx] = 1'b1;
`endif
    pend_ltp_n = ((pend_ltp & ~clr_ltp) | set_ltp) & ~wr_mask;
    pend_ltd_n = ((pend_ltd & ~clr_ltd) | set_ltd) & ~wr_mask;
  end

  // Pending bits and their latched pair distances.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_ltp <= '0;
      pend_ltd <= '0;
      for (int unsigned i = 0; i < N_SYN; i++) begin
        dt_ltp[i] <= '0;
        dt_ltd[i] <= '0;
      end
    end else begin
      pend_ltp <= pend_ltp_n;
      pend_ltd <= pend_ltd_n;
      for (int unsigned i = 0; i < N_SYN; i++) begin
        if (set_ltp[i]) dt_ltp[i] <= cap_dt_ltp[i];
        if (set_ltd[i]) dt_ltd[i] <= post_timer;
      end
    end
  end

  // Weight step and saturating add/subtract for the selected synapse.
  always_comb begin
    dw     = W_WIDTH'(stdp_dw(kind ? A_PLUS : A_MINUS, 32'(dt_sel), TAU_SHIFT, W_WIDTH));
    w_sum  = {1'b0, w_cur} + {1'b0, dw};
    w_diff = {1'b0, w_cur} - {1'b0, dw};
    w_new  = '0;
    w_sat  = 1'b0;
    if (kind) begin
      if (w_sum[W_WIDTH]) begin
        w_new = '1;
        w_sat = 1'b1;
      end else begin
        w_new = w_sum[W_WIDTH-1:0];
      end
    end else begin
      if (w_diff[W_WIDTH]) begin
        w_new = '0;
        w_sat = 1'b1;
      end else begin
        w_new = w_diff[W_WIDTH-1:0];
      end
    end
  end

  // Engine registers. The update result is registered at the end of CALC so
  // the upd_* pulse lines up with the WRITE cycle, which then commits it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel        <= '0;
      kind       <= 1'b0;
      dt_sel     <= '0;
      ptr        <= '0;
      upd_valid  <= 1'b0;
      upd_idx    <= '0;
      upd_ltp    <= 1'b0;
      upd_weight <= '0;
      upd_sat    <= 1'b0;
    end else begin
      upd_valid <= do_calc;
      if (grab) begin
        sel    <= arb_idx;
        kind   <= grab_ltp;
        dt_sel <= grab_dt;
      end
      if (do_calc) begin
        upd_idx    <= sel;
        upd_ltp    <= kind;
        upd_weight <= w_new;
        upd_sat    <= w_sat;
      end
      if (do_write) ptr <= (32'(sel) == N_SYN - 1) ? '0 : sel + 3'd1;
    end
  end

  // Weight registers; a config write lands after the engine write and wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_SYN; i++) w[i] <= W_WIDTH'(W_INIT);
    end else begin
      if (do_write) w[sel] <= upd_weight;
`ifdef STDP_WEIGHT_LOAD_EN
      if (wr_en && (32'(wr_idx) < N_SYN)) w[wr_idx] <= wr_data;
`endif
    end
  end

  // Flatten the weight registers onto the output bus.
  always_comb begin
    weights = '0;
    for (int unsigned i = 0; i < N_SYN; i++) weights[i*W_WIDTH +: W_WIDTH] = w[i];
  end

endmodule
